// File: rtl/axi_decerr_responder.sv
// AXI4 default slave: completes every AW/W/AR transaction with DECERR.
// Ports: clk_i, rst_ni (sync, active-low); AXI AW/W/B/AR/R channels;
//        err_cnt_o (saturating DECERR count), err_addr_o (last accepted addr).
module axi_decerr_responder #(
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [DataWidth-1:0] RespData = DataWidth'(64'hDEC0_DEC0_DEC0_DEC0)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [15:0]          err_cnt_o,
    output logic [AddrWidth-1:0] err_addr_o
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]           r_wstate;
    logic [IdWidth-1:0]   r_bid;
    logic [0:0]           r_rstate;
    logic [IdWidth-1:0]   r_rid;
    logic [7:0]           r_beats;
    logic [15:0]          r_err_cnt;
    logic [AddrWidth-1:0] r_err_addr;

    logic        w_aw_hs;
    logic        w_w_last_hs;
    logic        w_b_hs;
    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_rlast_hs;
    logic [16:0] w_cnt_sum;
    logic [15:0] w_cnt_next;
    logic        w_unused;

    // Burst length is irrelevant on writes: w_last_i alone ends the burst.
    assign w_unused = ^aw_len_i;

    // Everything handshake-related is gated so reset forces a quiet bus.
    assign aw_ready_o = rst_ni & (r_wstate == W_IDLE);
    assign w_ready_o  = rst_ni & (r_wstate == W_DATA);
    assign b_valid_o  = rst_ni & (r_wstate == W_RESP);
    assign b_id_o     = rst_ni ? r_bid : '0;
    assign b_resp_o   = 2'b11;

    assign ar_ready_o = rst_ni & (r_rstate == R_IDLE);
    assign r_valid_o  = rst_ni & (r_rstate == R_DATA);
    assign r_id_o     = rst_ni ? r_rid : '0;
    assign r_data_o   = RespData;
    assign r_resp_o   = 2'b11;
    assign r_last_o   = (r_beats == 8'd0);

    assign w_aw_hs     = aw_valid_i & aw_ready_o;
    assign w_w_last_hs = w_valid_i & w_ready_o & w_last_i;
    assign w_b_hs      = b_valid_o & b_ready_i;
    assign w_ar_hs     = ar_valid_i & ar_ready_o;
    assign w_r_hs      = r_valid_o & r_ready_i;
    assign w_rlast_hs  = w_r_hs & r_last_o;

    // Up to +2 per cycle; the 17th bit flags overflow so we clamp, not wrap.
    assign w_cnt_sum  = {1'b0, r_err_cnt} + 17'(w_b_hs) + 17'(w_rlast_hs);
    assign w_cnt_next = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

    assign err_cnt_o  = r_err_cnt;
    assign err_addr_o = r_err_addr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wstate <= W_IDLE;
            r_bid    <= '0;
        end else begin
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate <= W_DATA;
                        r_bid    <= aw_id_i;
                    end
                end
                W_DATA: begin
                    if (w_w_last_hs) r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (w_b_hs) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_beats  <= 8'd0;
        end else if (r_rstate == R_IDLE) begin
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rid    <= ar_id_i;
                r_beats  <= ar_len_i;
            end
        end else if (w_r_hs) begin
            if (r_last_o) r_rstate <= R_IDLE;
            else          r_beats  <= r_beats - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err_cnt  <= 16'd0;
            r_err_addr <= '0;
        end else begin
            r_err_cnt <= w_cnt_next;
            // AW wins a same-cycle tie with AR.
            if (w_aw_hs)      r_err_addr <= aw_addr_i;
            else if (w_ar_hs) r_err_addr <= ar_addr_i;
        end
    end

endmodule

// File: tb/tb_axi_decerr_responder.sv
// Directed bench for axi_decerr_responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_decerr_responder;

    localparam logic [63:0] RD = 64'hDEC0_DEC0_DEC0_DEC0;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid_i = 1'b0;
    logic        aw_ready_o;
    logic [4:0]  aw_id_i = '0;
    logic [63:0] aw_addr_i = '0;
    logic [7:0]  aw_len_i = '0;
    logic        w_valid_i = 1'b0;
    logic        w_ready_o;
    logic        w_last_i = 1'b0;
    logic        b_valid_o;
    logic        b_ready_i = 1'b0;
    logic [4:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i = 1'b0;
    logic        ar_ready_o;
    logic [4:0]  ar_id_i = '0;
    logic [63:0] ar_addr_i = '0;
    logic [7:0]  ar_len_i = '0;
    logic        r_valid_o;
    logic        r_ready_i = 1'b0;
    logic [4:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [15:0] err_cnt_o;
    logic [63:0] err_addr_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_decerr_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .aw_len_i   (aw_len_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_addr_i  (ar_addr_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o),
        .err_cnt_o  (err_cnt_o),
        .err_addr_o (err_addr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int  beats;
        int  bad;
        bit  done;
        bit  ar_early;
        bit  prev_stall;
        bit  pl;
        logic [4:0] pid;

        // reset state
        step();
        step();
        chk("rst_awrdy", 64'(aw_ready_o), 0);
        chk("rst_arrdy", 64'(ar_ready_o), 0);
        chk("rst_wrdy",  64'(w_ready_o), 0);
        chk("rst_bval",  64'(b_valid_o), 0);
        chk("rst_rval",  64'(r_valid_o), 0);
        chk("rst_cnt",   64'(err_cnt_o), 0);
        chk("rst_addr",  err_addr_o, 0);
        rst_ni = 1'b1;
        #1;
        chk("idle_awrdy", 64'(aw_ready_o), 1);
        chk("idle_arrdy", 64'(ar_ready_o), 1);

        // W before AW is not accepted
        w_valid_i = 1'b1;
        w_last_i  = 1'b1;
        #1;
        chk("w_early", 64'(w_ready_o), 0);
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;

        // single write
        aw_valid_i = 1'b1;
        aw_id_i    = 5'd5;
        aw_addr_i  = 64'h5000_0010;
        step();
        aw_valid_i = 1'b0;
        chk("wr_wrdy", 64'(w_ready_o), 1);
        chk("wr_bval0", 64'(b_valid_o), 0);
        w_valid_i = 1'b1;
        w_last_i  = 1'b1;
        step();
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        chk("wr_bval", 64'(b_valid_o), 1);
        chk("wr_bid", 64'(b_id_o), 5);
        chk("wr_bresp", 64'(b_resp_o), 3);
        chk("wr_addr", err_addr_o, 64'h5000_0010);
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        chk("wr_cnt", 64'(err_cnt_o), 1);
        chk("wr_bval_off", 64'(b_valid_o), 0);
        chk("wr_awrdy", 64'(aw_ready_o), 1);

        // read burst len=3, r_ready held high
        ar_valid_i = 1'b1;
        ar_id_i    = 5'd3;
        ar_len_i   = 8'd3;
        ar_addr_i  = 64'h5000_0100;
        step();
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("rd_val%0d", b), 64'(r_valid_o), 1);
            chk($sformatf("rd_id%0d", b), 64'(r_id_o), 3);
            chk($sformatf("rd_dat%0d", b), r_data_o, RD);
            chk($sformatf("rd_resp%0d", b), 64'(r_resp_o), 3);
            chk($sformatf("rd_last%0d", b), 64'(r_last_o), 64'(b == 3));
            chk($sformatf("rd_arrdy%0d", b), 64'(ar_ready_o), 0);
            step();
        end
        r_ready_i = 1'b0;
        chk("rd_done_val", 64'(r_valid_o), 0);
        chk("rd_done_arrdy", 64'(ar_ready_o), 1);
        chk("rd_cnt", 64'(err_cnt_o), 2);
        chk("rd_addr", err_addr_o, 64'h5000_0100);

        // backpressure: len=255, random r_ready, second AR pending
        ar_valid_i = 1'b1;
        ar_id_i    = 5'd7;
        ar_len_i   = 8'd255;
        ar_addr_i  = 64'h5000_0200;
        step();
        ar_id_i    = 5'd9;
        ar_len_i   = 8'd0;
        ar_addr_i  = 64'h6000_0000;
        beats = 0;
        bad = 0;
        done = 1'b0;
        ar_early = 1'b0;
        prev_stall = 1'b0;
        pl = 1'b0;
        pid = '0;
        for (int c = 0; c < 3000 && !done; c++) begin
            r_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (ar_ready_o) ar_early = 1'b1;
            if (!r_valid_o) bad++;
            if (prev_stall && (r_last_o !== pl || r_id_o !== pid)) bad++;
            if (r_valid_o && r_ready_i) begin
                if (r_last_o !== (beats == 255)) bad++;
                if (r_id_o !== 5'd7) bad++;
                beats++;
                if (r_last_o) done = 1'b1;
            end
            prev_stall = r_valid_o && !r_ready_i;
            pl = r_last_o;
            pid = r_id_o;
            step();
        end
        r_ready_i = 1'b0;
        chk("bp_done", 64'(done), 1);
        chk("bp_beats", 64'(beats), 256);
        chk("bp_bad", 64'(bad), 0);
        chk("bp_ar_early", 64'(ar_early), 0);
        chk("bp_cnt", 64'(err_cnt_o), 3);
        chk("bp_arrdy", 64'(ar_ready_o), 1);
        step();
        ar_valid_i = 1'b0;
        chk("bp2_val", 64'(r_valid_o), 1);
        chk("bp2_id", 64'(r_id_o), 9);
        chk("bp2_last", 64'(r_last_o), 1);
        chk("bp2_addr", err_addr_o, 64'h6000_0000);
        r_ready_i = 1'b1;
        step();
        r_ready_i = 1'b0;
        chk("bp2_off", 64'(r_valid_o), 0);
        chk("bp2_cnt", 64'(err_cnt_o), 4);

        // concurrency: AW+AR same cycle, then B and final R same cycle
        aw_valid_i = 1'b1;
        aw_id_i    = 5'd1;
        aw_addr_i  = 64'h1000;
        ar_valid_i = 1'b1;
        ar_id_i    = 5'd2;
        ar_len_i   = 8'd1;
        ar_addr_i  = 64'h2000;
        step();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        chk("cc_addr", err_addr_o, 64'h1000);
        w_valid_i = 1'b1;
        w_last_i  = 1'b1;
        step();
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        r_ready_i = 1'b1;
        step();
        chk("cc_bval", 64'(b_valid_o), 1);
        chk("cc_rlast", 64'(r_last_o), 1);
        chk("cc_cnt0", 64'(err_cnt_o), 4);
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        chk("cc_cnt2", 64'(err_cnt_o), 6);

        // saturation: preload 0xFFFE, then a +2 cycle and a +1
        force dut.r_err_cnt = 16'hFFFE;
        step();
        release dut.r_err_cnt;
        step();
        chk("sat_pre", 64'(err_cnt_o), 64'hFFFE);
        aw_valid_i = 1'b1;
        ar_valid_i = 1'b1;
        ar_len_i   = 8'd0;
        step();
        aw_valid_i = 1'b0;
        ar_valid_i = 1'b0;
        w_valid_i  = 1'b1;
        w_last_i   = 1'b1;
        step();
        w_valid_i = 1'b0;
        w_last_i  = 1'b0;
        b_ready_i = 1'b1;
        r_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        r_ready_i = 1'b0;
        chk("sat_2", 64'(err_cnt_o), 64'hFFFF);
        ar_valid_i = 1'b1;
        step();
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        step();
        r_ready_i = 1'b0;
        chk("sat_1", 64'(err_cnt_o), 64'hFFFF);

        // reset mid-burst
        ar_valid_i = 1'b1;
        ar_id_i    = 5'd4;
        ar_len_i   = 8'd7;
        ar_addr_i  = 64'h5000_0300;
        step();
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        step();
        step();
        chk("mr_val", 64'(r_valid_o), 1);
        chk("mr_last", 64'(r_last_o), 0);
        rst_ni = 1'b0;
        step();
        r_ready_i = 1'b0;
        chk("mr_rval", 64'(r_valid_o), 0);
        chk("mr_cnt", 64'(err_cnt_o), 0);
        chk("mr_addr", err_addr_o, 0);
        chk("mr_rid", 64'(r_id_o), 0);
        rst_ni = 1'b1;
        step();
        chk("mr_idle", 64'(r_valid_o), 0);
        chk("mr_arrdy", 64'(ar_ready_o), 1);
        ar_valid_i = 1'b1;
        ar_id_i    = 5'd6;
        ar_len_i   = 8'd1;
        ar_addr_i  = 64'h7000_0000;
        step();
        ar_valid_i = 1'b0;
        r_ready_i  = 1'b1;
        chk("mr_b0_id", 64'(r_id_o), 6);
        chk("mr_b0_last", 64'(r_last_o), 0);
        step();
        chk("mr_b1_val", 64'(r_valid_o), 1);
        chk("mr_b1_last", 64'(r_last_o), 1);
        step();
        r_ready_i = 1'b0;
        chk("mr_cnt1", 64'(err_cnt_o), 1);
        chk("mr_addr1", err_addr_o, 64'h7000_0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
